// File: rtl/rename_dispatch_stage.sv
// Rename/dispatch stage: owns the architectural-register map table, allocates
// ROB tags through a valid/ready handshake, renames source operands to ROB tags
// and dispatches one instruction per cycle through a single output register to
// one of NUM_RS reservation stations. Supports per-station backpressure, commit
// clearing of map entries and full pipeline flush.
module rename_dispatch_stage #(
  parameter int ROB_SIZE  = 32,
  parameter int TAG_W     = $clog2(ROB_SIZE + 1),
  parameter int ARCH_REGS = 32,
  parameter int REG_W     = $clog2(ARCH_REGS),
  parameter int ZERO_REG  = 31,
  parameter int NUM_RS    = 4,
  parameter int RS_SEL_W  = $clog2(NUM_RS),
  parameter int CMD_W     = 10
) (
  input  logic                clk_i,
  input  logic                reset_i,
  // Decoded instruction handshake
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [REG_W-1:0]    in_rd_i,
  input  logic [REG_W-1:0]    in_rn_i,
  input  logic [REG_W-1:0]    in_rm_i,
  input  logic                in_reg_write_i,
  input  logic                in_src2_imm_i,
  input  logic [RS_SEL_W-1:0] in_rs_sel_i,
  input  logic [CMD_W-1:0]    in_cmd_i,
  // ROB allocation
  output logic                rob_alloc_o,
  input  logic                rob_alloc_ready_i,
  input  logic [TAG_W-1:0]    rob_tail_i,
  // ROB commit
  input  logic                commit_valid_i,
  input  logic [REG_W-1:0]    commit_reg_i,
  input  logic [TAG_W-1:0]    commit_tag_i,
  // Pipeline flush
  input  logic                flush_i,
  // Dispatch to reservation stations
  output logic [NUM_RS-1:0]   out_valid_o,
  input  logic [NUM_RS-1:0]   out_ready_i,
  output logic [TAG_W-1:0]    out_tag_o,
  output logic [TAG_W-1:0]    out_src1_tag_o,
  output logic [TAG_W-1:0]    out_src2_tag_o,
  output logic [REG_W-1:0]    out_rn_o,
  output logic [REG_W-1:0]    out_rm_o,
  output logic [CMD_W-1:0]    out_cmd_o
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  // Map table: 0 means "value is architectural, read the regfile".
  logic [TAG_W-1:0] map_q [ARCH_REGS];
  logic [TAG_W-1:0] map_d [ARCH_REGS];

  // Output slot registers.
  logic [NUM_RS-1:0] out_valid_q, out_valid_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic [TAG_W-1:0]  out_src1_tag_q, out_src1_tag_d;
  logic [TAG_W-1:0]  out_src2_tag_q, out_src2_tag_d;
  logic [REG_W-1:0]  out_rn_q, out_rn_d;
  logic [REG_W-1:0]  out_rm_q, out_rm_d;
  logic [CMD_W-1:0]  out_cmd_q, out_cmd_d;

  logic              held;
  logic              held_drain;
  logic              accept;
  logic [TAG_W-1:0]  src1_tag;
  logic [TAG_W-1:0]  src2_tag;
  logic [NUM_RS-1:0] sel_onehot;

  // Source tag lookup: the zero register and an entry retiring this very cycle
  // both resolve to the regfile.
  function automatic logic [TAG_W-1:0] src_tag(
    input logic [REG_W-1:0] r,
    input logic [TAG_W-1:0] entry,
    input logic             cv,
    input logic [REG_W-1:0] creg,
    input logic [TAG_W-1:0] ctag
  );
    logic [TAG_W-1:0] t;
    t = entry;
    if (r == ZERO_IDX) begin
      t = '0;
    end else if (cv && (creg == r) && (ctag == entry)) begin
      t = '0;
    end
    return t;
  endfunction

  // The slot is one-hot, so masking with out_ready_i picks the held station's ready.
  assign held       = |out_valid_q;
  assign held_drain = |(out_valid_q & out_ready_i);
  assign in_ready_o = reset_i & ~flush_i & rob_alloc_ready_i & (~held | held_drain);
  assign accept     = in_valid_i & in_ready_o;
  assign rob_alloc_o = accept;

  assign src1_tag   = src_tag(in_rn_i, map_q[in_rn_i], commit_valid_i, commit_reg_i, commit_tag_i);
  assign src2_tag   = in_src2_imm_i ? '0
                    : src_tag(in_rm_i, map_q[in_rm_i], commit_valid_i, commit_reg_i, commit_tag_i);
  assign sel_onehot = NUM_RS'(1) << in_rs_sel_i;

  // Map next state: flush clears everything, otherwise commit clear then rename.
  always_comb begin
    // NOTE: blocking assignments in combinational logic; the later rename write
    // overrides the earlier commit clear, which is exactly "rename wins".
    map_d = map_q;
    if (flush_i) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_d[i] = '0;
      end
    end else begin
      if (commit_valid_i && (map_q[commit_reg_i] == commit_tag_i)) begin
        map_d[commit_reg_i] = '0;
      end
      if (accept && in_reg_write_i && (in_rd_i != ZERO_IDX)) begin
        map_d[in_rd_i] = rob_tail_i;
      end
    end
  end

  // Output slot next state: load on accept, drop on drain or flush, else hold.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_tag_d      = out_tag_q;
    out_src1_tag_d = out_src1_tag_q;
    out_src2_tag_d = out_src2_tag_q;
    out_rn_d       = out_rn_q;
    out_rm_d       = out_rm_q;
    out_cmd_d      = out_cmd_q;
    if (flush_i) begin
      out_valid_d = '0;
    end else if (accept) begin
      out_valid_d    = sel_onehot;
      out_tag_d      = rob_tail_i;
      out_src1_tag_d = src1_tag;
      out_src2_tag_d = src2_tag;
      out_rn_d       = in_rn_i;
      out_rm_d       = in_rm_i;
      out_cmd_d      = in_cmd_i;
    end else if (held_drain) begin
      out_valid_d = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      // NOTE: the map is reset (unlike a plain data RAM) because a leftover tag
      // would make consumers wait on a ROB entry that will never broadcast.
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i] <= '0;
      end
      out_valid_q    <= '0;
      out_tag_q      <= '0;
      out_src1_tag_q <= '0;
      out_src2_tag_q <= '0;
      out_rn_q       <= '0;
      out_rm_q       <= '0;
      out_cmd_q      <= '0;
    end else begin
      map_q          <= map_d;
      out_valid_q    <= out_valid_d;
      out_tag_q      <= out_tag_d;
      out_src1_tag_q <= out_src1_tag_d;
      out_src2_tag_q <= out_src2_tag_d;
      out_rn_q       <= out_rn_d;
      out_rm_q       <= out_rm_d;
      out_cmd_q      <= out_cmd_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_tag_o      = out_tag_q;
  assign out_src1_tag_o = out_src1_tag_q;
  assign out_src2_tag_o = out_src2_tag_q;
  assign out_rn_o       = out_rn_q;
  assign out_rm_o       = out_rm_q;
  assign out_cmd_o      = out_cmd_q;

  // Widened select so the range check is meaningful for any NUM_RS.
  logic [RS_SEL_W:0] sel_ext;
  assign sel_ext = {1'b0, in_rs_sel_i};

  a_rs_sel_legal: assert property (@(posedge clk_i) disable iff (!reset_i)
    in_valid_i |-> (sel_ext < (RS_SEL_W + 1)'(NUM_RS)));

  a_out_onehot: assert property (@(posedge clk_i) disable iff (!reset_i)
    $onehot0(out_valid_q));

endmodule

// File: tb/tb_rename_dispatch_stage.sv
// Self-checking bench for rename_dispatch_stage: a driver issues directed then
// random instructions, a reference model predicts each dispatch into a
// scoreboard queue, and a monitor compares whatever the stage presents.
module tb_rename_dispatch_stage;

  localparam int TAG_W  = 6;
  localparam int REG_W  = 5;
  localparam int NUM_RS = 4;
  localparam int SEL_W  = 2;
  localparam int CMD_W  = 10;
  localparam int ZR     = 31;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              reset_i;
  logic              in_valid_i, in_ready_o;
  logic [REG_W-1:0]  in_rd_i, in_rn_i, in_rm_i;
  logic              in_reg_write_i, in_src2_imm_i;
  logic [SEL_W-1:0]  in_rs_sel_i;
  logic [CMD_W-1:0]  in_cmd_i;
  logic              rob_alloc_o, rob_alloc_ready_i;
  logic [TAG_W-1:0]  rob_tail_i;
  logic              commit_valid_i;
  logic [REG_W-1:0]  commit_reg_i;
  logic [TAG_W-1:0]  commit_tag_i;
  logic              flush_i;
  logic [NUM_RS-1:0] out_valid_o, out_ready_i;
  logic [TAG_W-1:0]  out_tag_o, out_src1_tag_o, out_src2_tag_o;
  logic [REG_W-1:0]  out_rn_o, out_rm_o;
  logic [CMD_W-1:0]  out_cmd_o;

  rename_dispatch_stage dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_rd_i(in_rd_i), .in_rn_i(in_rn_i), .in_rm_i(in_rm_i),
    .in_reg_write_i(in_reg_write_i), .in_src2_imm_i(in_src2_imm_i),
    .in_rs_sel_i(in_rs_sel_i), .in_cmd_i(in_cmd_i),
    .rob_alloc_o(rob_alloc_o), .rob_alloc_ready_i(rob_alloc_ready_i),
    .rob_tail_i(rob_tail_i),
    .commit_valid_i(commit_valid_i), .commit_reg_i(commit_reg_i),
    .commit_tag_i(commit_tag_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_tag_o(out_tag_o), .out_src1_tag_o(out_src1_tag_o),
    .out_src2_tag_o(out_src2_tag_o), .out_rn_o(out_rn_o), .out_rm_o(out_rm_o),
    .out_cmd_o(out_cmd_o)
  );

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd, rn, rm;
    logic             wr, imm;
    logic [SEL_W-1:0] sel;
    logic [CMD_W-1:0] cmd;
    logic             alloc;
    logic [TAG_W-1:0] tail;
    logic             cv;
    logic [REG_W-1:0] creg;
    logic [TAG_W-1:0] ctag;
    logic             flush;
    logic [NUM_RS-1:0] ordy;
  } stim_t;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [TAG_W-1:0] tag, s1, s2;
    logic [REG_W-1:0] rn, rm;
    logic [CMD_W-1:0] cmd;
    int               due;
  } exp_t;

  // Reference model state: architectural map, output slot occupancy, scoreboard.
  logic [TAG_W-1:0] mmap [32];
  bit               slot_v;
  logic [SEL_W-1:0] slot_sel;
  exp_t             sbq[$];
  exp_t             mon_e;
  int               cyc;
  int               n_checks;
  int               n_errors;
  bit               mon_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Tag a source register reads, from the map as it stood before this instruction.
  function automatic logic [TAG_W-1:0] lookup(input logic [REG_W-1:0] r, input stim_t s);
    if (r == REG_W'(ZR)) return '0;
    if (s.cv && s.creg == r && s.ctag == mmap[r]) return '0;
    return mmap[r];
  endfunction

  function automatic stim_t ins(input int rd, input int rn, input int rm, input int sel,
                                input int tail, input logic [NUM_RS-1:0] ordy);
    stim_t s;
    s       = '0;
    s.v     = 1'b1;
    s.wr    = 1'b1;
    s.alloc = 1'b1;
    s.rd    = REG_W'(rd);
    s.rn    = REG_W'(rn);
    s.rm    = REG_W'(rm);
    s.sel   = SEL_W'(sel);
    s.tail  = TAG_W'(tail);
    s.cmd   = CMD_W'($urandom);
    s.ordy  = ordy;
    return s;
  endfunction

  function automatic logic [REG_W-1:0] pick();
    int k;
    k = int'($urandom_range(0, 4));
    return (k == 4) ? REG_W'(ZR) : REG_W'(k);
  endfunction

  // One cycle: drive, check the handshake, predict the dispatch, advance the model.
  task automatic step(input stim_t s);
    bit   exp_rdy, acc;
    exp_t e;
    @(posedge clk_i);
    #1;
    in_valid_i = s.v;  in_rd_i = s.rd;  in_rn_i = s.rn;  in_rm_i = s.rm;
    in_reg_write_i = s.wr;  in_src2_imm_i = s.imm;  in_rs_sel_i = s.sel;
    in_cmd_i = s.cmd;  rob_alloc_ready_i = s.alloc;  rob_tail_i = s.tail;
    commit_valid_i = s.cv;  commit_reg_i = s.creg;  commit_tag_i = s.ctag;
    flush_i = s.flush;  out_ready_i = s.ordy;
    #1;
    exp_rdy = !s.flush && s.alloc && (!slot_v || s.ordy[slot_sel]);
    acc     = s.v && exp_rdy;
    check("in_ready", 64'(in_ready_o), 64'(exp_rdy));
    check("rob_alloc", 64'(rob_alloc_o), 64'(acc));
    if (acc) begin
      e.sel = s.sel;  e.tag = s.tail;
      e.s1  = lookup(s.rn, s);
      e.s2  = s.imm ? '0 : lookup(s.rm, s);
      e.rn  = s.rn;  e.rm = s.rm;  e.cmd = s.cmd;
      e.due = cyc + 1;
      sbq.push_back(e);
    end
    if (s.flush) begin
      foreach (mmap[i]) mmap[i] = '0;
      slot_v = 1'b0;
    end else begin
      if (s.cv && mmap[s.creg] == s.ctag) mmap[s.creg] = '0;
      if (acc && s.wr && s.rd != REG_W'(ZR)) mmap[s.rd] = s.tail;
      if (acc) begin
        slot_v   = 1'b1;
        slot_sel = s.sel;
      end else if (slot_v && s.ordy[slot_sel]) begin
        slot_v = 1'b0;
      end
    end
  endtask

  // Monitor: compare every presented dispatch with the scoreboard head.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (out_valid_o != '0) begin
        if (sbq.size() == 0) begin
          check("unexpected_dispatch", 64'(out_valid_o), 64'd0);
        end else begin
          mon_e = sbq[0];
          check("dispatch_valid", 64'(out_valid_o), 64'(4'b0001 << mon_e.sel));
          check("dispatch_payload",
                64'({out_tag_o, out_src1_tag_o, out_src2_tag_o, out_rn_o, out_rm_o, out_cmd_o}),
                64'({mon_e.tag, mon_e.s1, mon_e.s2, mon_e.rn, mon_e.rm, mon_e.cmd}));
          check("dispatch_early", 64'(mon_e.due <= cyc), 64'd1);
          if (flush_i || ((out_valid_o & out_ready_i) != '0)) void'(sbq.pop_front());
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        check("missing_dispatch", 64'(out_valid_o), 64'(4'b0001 << sbq[0].sel));
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    n_checks = 0;  n_errors = 0;  cyc = 0;  mon_en = 1'b0;  slot_v = 1'b0;  slot_sel = '0;
    foreach (mmap[i]) mmap[i] = '0;
    reset_i = 1'b0;  in_valid_i = 1'b1;  in_rd_i = 5'd1;  in_rn_i = '0;  in_rm_i = '0;
    in_reg_write_i = 1'b1;  in_src2_imm_i = 1'b0;  in_rs_sel_i = '0;  in_cmd_i = '0;
    rob_alloc_ready_i = 1'b1;  rob_tail_i = 6'd3;  commit_valid_i = 1'b0;
    commit_reg_i = '0;  commit_tag_i = '0;  flush_i = 1'b0;  out_ready_i = '0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_out_valid", 64'(out_valid_o), 64'd0);
    check("reset_out_regs",
          64'({out_tag_o, out_src1_tag_o, out_src2_tag_o, out_rn_o, out_rm_o, out_cmd_o}), 64'd0);
    check("reset_in_ready", 64'(in_ready_o), 64'd0);
    check("reset_rob_alloc", 64'(rob_alloc_o), 64'd0);
    in_valid_i = 1'b0;
    reset_i    = 1'b1;
    mon_en     = 1'b1;

    // Directed sequence.
    step(ins(1, 2, 3, 2, 5, 4'b0000));                      // x1<-x2,x3 tail 5 -> RS2
    step(ins(4, 1, 1, 0, 6, 4'b0100));                      // reads x1 -> 5/5
    s = ins(5, 1, 2, 1, 7, 4'b0001); s.cv = 1; s.creg = 1; s.ctag = 3; step(s);  // stale commit
    s = ins(6, 1, 3, 3, 8, 4'b0010); s.cv = 1; s.creg = 1; s.ctag = 5; step(s);  // bypass to 0
    repeat (3) step(ins(7, 1, 1, 3, 9, 4'b0000));           // hold, stage blocked
    s = ins(7, 1, 1, 0, 9, 4'b1000); s.v = 0; step(s);      // single transfer
    s = ins(7, 1, 1, 0, 9, 4'b1111); s.v = 0; step(s);      // no duplicate
    step(ins(2, 1, 1, 0, 10, 4'b0000));                     // x1 cleared -> 0
    s = ins(1, 2, 2, 0, 11, 4'b1111); s.alloc = 0; step(s); // ROB full: no accept
    step(ins(1, 2, 2, 1, 12, 4'b1111));                     // x1 <- 12
    step(ins(3, 1, 0, 1, 13, 4'b0000));                     // src1 12, hold on RS1
    s = ins(8, 1, 1, 0, 20, 4'b0000); s.flush = 1; step(s); // flush while held
    step(ins(4, 1, 1, 0, 14, 4'b1111));                     // map empty -> 0/0
    step(ins(31, 2, 2, 0, 15, 4'b1111));                    // zero reg not renamed
    step(ins(5, 31, 31, 0, 16, 4'b1111));
    s = ins(6, 4, 4, 0, 17, 4'b1111); s.imm = 1; step(s);   // immediate src2

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      s       = '0;
      s.v     = ($urandom_range(0, 3) != 0);
      s.rd    = pick();  s.rn = pick();  s.rm = pick();
      s.wr    = ($urandom_range(0, 3) != 0);
      s.imm   = ($urandom_range(0, 3) == 0);
      s.sel   = SEL_W'($urandom_range(0, NUM_RS - 1));
      s.cmd   = CMD_W'($urandom);
      s.alloc = ($urandom_range(0, 7) != 0);
      s.tail  = TAG_W'($urandom_range(1, 32));
      s.cv    = ($urandom_range(0, 2) == 0);
      s.creg  = pick();
      s.ctag  = ($urandom_range(0, 1) == 1) ? mmap[s.creg] : TAG_W'($urandom_range(0, 32));
      s.flush = ($urandom_range(0, 49) == 0);
      s.ordy  = NUM_RS'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? 4'b1111 : 4'b0000);
      step(s);
    end

    // Drain the slot and confirm every prediction was seen.
    for (int n = 0; n < 10 && sbq.size() != 0; n++) begin
      s = '0; s.ordy = 4'b1111; s.alloc = 1'b1;
      step(s);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    check("drain_empty", 64'(sbq.size()), 64'd0);
    check("final_out_valid", 64'(out_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rename_dispatch_stage.md
Name: rename_dispatch_stage

Overview:
- Registered successor to the combinational decode stage.
- Owns the architectural-register map table internally and allocates ROB tags through a valid/ready handshake.
- Renames source operands to ROB tags and dispatches one instruction per cycle through an output register to one of NUM_RS reservation stations.
- Supports backpressure per station, ROB-commit map clearing, and full pipeline flush.

Parameters:
ROB_SIZE, 32, ROB entries; tag 0 reserved for "value in regfile"
TAG_W, $clog2(ROB_SIZE+1), ROB tag width
ARCH_REGS, 32, architectural register count
REG_W, $clog2(ARCH_REGS), architectural register address width
ZERO_REG, 31, hard-wired zero register; never renamed
NUM_RS, 4, number of reservation stations
RS_SEL_W, $clog2(NUM_RS), station select width
CMD_W, 10, opaque command bundle width

Ports:
clk_i  in  1  clock
reset_i  in  1  reset, synchronous, active-low
in_valid_i  in  1  decoded instruction valid
in_ready_o  out  1  stage accepts instruction this cycle
in_rd_i  in  REG_W  destination register
in_rn_i  in  REG_W  source 1 register
in_rm_i  in  REG_W  source 2 register
in_reg_write_i  in  1  instruction writes rd
in_src2_imm_i  in  1  source 2 is immediate; tag forced 0
in_rs_sel_i  in  RS_SEL_W  target station
in_cmd_i  in  CMD_W  command bundle
rob_alloc_o  out  1  ROB tail allocate pulse
rob_alloc_ready_i  in  1  ROB not full
rob_tail_i  in  TAG_W  tag allocated on accept (never 0)
commit_valid_i  in  1  ROB commit this cycle
commit_reg_i  in  REG_W  committed destination register
commit_tag_i  in  TAG_W  committed ROB tag
flush_i  in  1  squash in-flight state
out_valid_o  out  NUM_RS  one-hot dispatch valid
out_ready_i  in  NUM_RS  per-station ready
out_tag_o  out  TAG_W  instruction ROB tag
out_src1_tag_o  out  TAG_W  source 1 tag (0 = read regfile)
out_src2_tag_o  out  TAG_W  source 2 tag (0 = regfile/immediate)
out_rn_o, out_rm_o  out  REG_W  source register numbers for regfile read
out_cmd_o  out  CMD_W  registered command bundle

Behaviour:
- Reset (reset_i=0 at clk edge):
  - All map entries become 0.
  - out_valid_o=0; every other out_* register becomes 0.
  - rob_alloc_o=0.
- Output slot and in_ready_o:
  - Single output register; it is "held" while out_valid_o!=0.
  - in_ready_o = reset_i & ~flush_i & rob_alloc_ready_i & (~held | out_ready_i[held station]).
  - Combinational from inputs and state; it does not depend on in_valid_i.
- Accept (in_valid_i & in_ready_o):
  - rob_alloc_o=1 in the same cycle (combinational).
  - On the next edge the output register loads: out_valid_o = one-hot(in_rs_sel_i), out_tag_o = rob_tail_i, the source tags, the register numbers, and cmd.
  - Latency is 1 cycle.
- Drain without accept: if held and out_ready_i[sel]=1 but no accept, out_valid_o clears.
- Hold: if held and out_ready_i[sel]=0, all out_* stay stable.
- Source tag lookup, performed at accept:
  - tag = map[reg].
  - reg==ZERO_REG → 0.
  - Commit bypass: commit_valid_i with commit_reg_i==reg and commit_tag_i==map[reg] → 0.
  - in_src2_imm_i=1 → src2 tag 0.
  - Sources read the map before this instruction's own rd update, so "add x1,x1,x1" reads the old x1 tag.
- Map write: on accept with in_reg_write_i=1 and in_rd_i!=ZERO_REG, map[in_rd_i] ← rob_tail_i.
- Commit:
  - If commit_valid_i and map[commit_reg_i]==commit_tag_i, that entry becomes 0.
  - A stale tag (the entry has since been renamed) leaves the entry unchanged.
  - Same-cycle rename and commit to the same register: the rename wins.
- Flush:
  - Highest priority below reset.
  - At the edge: all map entries become 0 and out_valid_o becomes 0.
  - in_ready_o=0 and rob_alloc_o=0 during the flush cycle; commit is ignored that cycle.
- Invalid select: in_rs_sel_i ≥ NUM_RS is illegal; assert in simulation.
- Invariant: out_valid_o is always one-hot or zero.

Test Plan:
- Reset, then accept "x1←x2,x3" with tail=5, sel=2 → next cycle out_valid_o=4'b0100, out_tag_o=5, src tags 0/0, map[1]=5.
- Then accept "x4←x1,x1", tail=6, sel=0 with out_ready_i=4'b0100 → src1=src2=5, out_tag_o=6, out_valid_o=4'b0001.
- Commit (x1, tag 5) in the same cycle as a lookup of x1 → src tag 0, map[1]=0. Commit (x1, tag 3) while map[1]=5 → map[1] stays 5.
- Hold with out_ready_i=0 for 3 cycles → outputs stable, in_ready_o=0. Then assert ready → one transfer, no duplicate.
- rob_alloc_ready_i=0 with in_valid_i=1 → in_ready_o=0, rob_alloc_o=0, map unchanged.
- flush_i pulse while held and with map[1]=5 → next cycle out_valid_o=0 and all map entries 0. Rename of rd=ZERO_REG leaves the map unchanged.
